// File: rtl/apb_master_bridge.sv
// APB initiator: one valid/ready command in, one SETUP->ACCESS transfer out, one response back.
// Optional ACCESS-phase timeout is enabled by defining APB_MST_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned ADDR_WD = 16,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic               PCLK,
    input  logic               PRESETn,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    input  logic [3:0]         cmd_strb,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic [1:0]         rsp_err,

    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_WD-1:0] PADDR,
    output logic [DATA_WD-1:0] PWDATA,
    output logic [3:0]         PSTRB,
    input  logic [DATA_WD-1:0] PRDATA,
    input  logic               PREADY,
    input  logic [1:0]         PSLVERR
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_WD-1:0] paddr_q, paddr_d;
    logic [DATA_WD-1:0] pwdata_q, pwdata_d;
    logic [3:0]         pstrb_q, pstrb_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_WD-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]         rsp_err_q, rsp_err_d;

    logic               tmo_clr;
    logic               tmo_hit;

    if (TMO_CYC < 1) begin : g_tmo_cyc_invalid
        $error("apb_master_bridge: TMO_CYC must be at least 1");
    end

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned TmoBits = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [TmoBits-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts ACCESS cycles without PREADY; the terminal count is the TMO_CYC-th such cycle.
    assign tmo_hit = (state_q == StAccess) && (tmo_cnt_q == TmoBits'(TMO_CYC - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_clr) begin
            tmo_cnt_d = '0;
        end else if ((state_q == StAccess) && !PREADY && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign cmd_ready = (state_q == StIdle);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        tmo_clr     = 1'b0;

        unique case (state_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pstrb_d   = cmd_write ? cmd_strb : 4'h0;
                    psel_d    = 1'b1;
                    state_d   = StSetup;
                end
            end

            StSetup: begin
                penable_d = 1'b1;
                tmo_clr   = 1'b1;
                state_d   = StAccess;
            end

            StAccess: begin
                // PREADY on the terminal timeout cycle still completes the transfer normally.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else if (tmo_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 2'b11;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end

            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
